lane_serializer_8bits: RTL

Per-lane parallel-to-serial stage sitting directly downstream of the 1x2 8-bit byte demux. It takes one lane's byte stream, buffers it in a small FIFO and shifts it out one bit per clock, eight cycles per symbol. Whenever no data byte is available, it fills the symbol slot with the idle/COM symbol. After reset it emits a fixed training run of idle symbols before it releases data.

---
 rtl/lane_pkg.sv | 15 +
 rtl/fifo_sync_8bits.sv | 71 +++++++
 rtl/lane_serializer_8bits.sv | 105 ++++++++++
 3 files changed

// File: rtl/lane_pkg.sv
// Shared definitions for the lane serializer: symbol width, idle symbol, FSM states.
package lane_pkg;

    localparam int SYM_W = 8;

    // K28.5 comma, sent whenever no data byte is available.
    localparam logic [SYM_W-1:0] IDLE_SYM_DEFAULT = 8'hBC;

    // INIT sends the training run of idle symbols; RUN releases data.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } lane_state_t;

endpackage

// File: rtl/fifo_sync_8bits.sv
// Small synchronous byte FIFO with registered full/empty and same-edge push/pop.
module fifo_sync_8bits
    import lane_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             push,
    input  logic [SYM_W-1:0] push_data,
    input  logic             pop,
    output logic [SYM_W-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [SYM_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             full_reg;
    logic             empty_reg;
    logic             push_ok;
    logic             pop_ok;

    // Requests are gated by the registered flags, so a push while full is dropped
    // even if a pop happens on the same edge.
    assign push_ok = push && !full_reg;
    assign pop_ok  = pop && !empty_reg;

    // Occupancy update; simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Pointers, count and flags; flags are precomputed from count_next.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
            full_reg  <= (count_next == CW'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= push_data;
    end

    assign head_data = mem[rd_ptr_reg];
    assign full      = full_reg;
    assign empty     = empty_reg;

endmodule

// File: rtl/lane_serializer_8bits.sv
// Per-lane parallel-to-serial stage: byte FIFO, idle training run, MSB-first shifter.
module lane_serializer_8bits
    import lane_pkg::*;
#(
    parameter int               FIFO_DEPTH = 4,
    parameter logic [SYM_W-1:0] IDLE_SYM   = IDLE_SYM_DEFAULT,
    parameter int               INIT_SYMS  = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [SYM_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             sym_start,
    output logic             fifo_empty,
    output logic             overflow
);

    localparam logic [3:0] IDLE_LAST = 4'(INIT_SYMS - 1);

    lane_state_t      state_reg;
    lane_state_t      state_next;
    logic [3:0]       idle_cnt_reg;
    logic [3:0]       idle_cnt_next;
    logic [2:0]       bit_cnt_reg;
    logic [SYM_W-1:0] shift_reg;
    logic             out_valid_reg;
    logic             overflow_reg;
    logic             sym_end;
    logic             pop;
    logic             fifo_full;
    logic [SYM_W-1:0] head_data;

    fifo_sync_8bits #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_L   (reset_L),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign sym_end = (bit_cnt_reg == 3'd7);

    // The boundary that ends the last training symbol already counts as RUN,
    // so the first data-capable symbol starts exactly INIT_SYMS*8 cycles after reset.
    assign pop = sym_end && (state_next == RUN) && !fifo_empty;

    // FSM register and idle symbol counter.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_reg    <= INIT;
            idle_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            idle_cnt_reg <= idle_cnt_next;
        end
    end

    // Next state: count completed idle symbols in INIT, then stay in RUN.
    always_comb begin
        state_next    = state_reg;
        idle_cnt_next = idle_cnt_reg;
        if (state_reg == INIT && sym_end) begin
            if (idle_cnt_reg == IDLE_LAST) state_next = RUN;
            else                           idle_cnt_next = idle_cnt_reg + 4'd1;
        end
    end

    // Bit counter, shifter and symbol-valid flag; a new symbol loads on the boundary.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            bit_cnt_reg   <= '0;
            shift_reg     <= IDLE_SYM;
            out_valid_reg <= 1'b0;
        end else begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (sym_end) begin
                shift_reg     <= pop ? head_data : IDLE_SYM;
                out_valid_reg <= pop;
            end else begin
                shift_reg <= {shift_reg[SYM_W-2:0], 1'b0};
            end
        end
    end

    // Sticky overflow: source presented data while the FIFO refused it.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) overflow_reg <= 1'b0;
        else          overflow_reg <= overflow_reg | (in_valid & fifo_full);
    end

    assign in_ready  = !fifo_full;
    assign out_bit   = shift_reg[SYM_W-1];
    assign out_valid = out_valid_reg;
    assign sym_start = (bit_cnt_reg == 3'd0);
    assign overflow  = overflow_reg;

endmodule
